sdram_port_arb: RTL and testbench

- Upstream front-end for the single-port byte-wide SDRAM controller.
- Arbitrates three clients: loader/ROM download, CPU, and video fetch.
- Generates the controller's clkref slot reference and its level oe/we/addr/din request signals.
- Returns read data and a one-cycle ack per client.
- Inserts guaranteed request-free slots so the controller issues auto-refresh.

---
 rtl/sdram_arb_pkg.sv | 26 ++
 rtl/sdram_slot_timer.sv | 49 ++++
 rtl/sdram_port_arb.sv | 142 ++++++++++++++
 tb/tb_sdram_port_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: client indices,
// grant encoding, the per-client request bundle and slot phase helper.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int NUM_PORTS    = 3;

    typedef logic [1:0] grant_t;

    localparam grant_t PORT_LOADER = 2'd0;
    localparam grant_t PORT_CPU    = 2'd1;
    localparam grant_t PORT_VIDEO  = 2'd2;
    localparam grant_t PORT_NONE   = 2'd3;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [7:0]              din;
    } port_req_t;

    function automatic int unsigned last_phase(input int unsigned slot_clks);
        return slot_clks - 1;
    endfunction

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot phase counter, clkref generation and refresh spacing counter.
// Strobes are combinational from registered state; no backpressure.
module sdram_slot_timer
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_CLKS     = 16,
    parameter int REFRESH_EVERY = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_vld,
    output logic clkref,
    output logic pre_end,
    output logic slot_end,
    output logic force_idle
);

    localparam int PH_W  = $clog2(SLOT_CLKS);
    localparam int CNT_W = $clog2(REFRESH_EVERY);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(last_phase(SLOT_CLKS));
    localparam logic [PH_W-1:0]  PH_PRE   = PH_LAST - PH_W'(1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_EVERY - 1);

    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_nxt;
    logic [CNT_W-1:0] ref_cnt;

    assign ph_nxt     = ph + PH_W'(1);
    assign pre_end    = (ph == PH_PRE);
    assign slot_end   = (ph == PH_LAST);
    assign force_idle = slot_end && (ref_cnt == REF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            ph      <= '0;
            clkref  <= 1'b0;
            ref_cnt <= '0;
        end else begin
            ph     <= ph_nxt;
            // high for the first half of the slot; MSB of next phase is 0 there
            clkref <= ~ph_nxt[PH_W-1];
            if (slot_end) begin
                ref_cnt <= grant_vld ? ref_cnt + CNT_W'(1) : '0;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Fixed-priority three-client front end for the byte-wide SDRAM controller.
// One access per slot, ack at the last slot phase; clients hold req until ack.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_CLKS     = 16,
    parameter int REFRESH_EVERY = 8,
    parameter int ADDR_W        = SDRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_din,
    output logic              p0_ack,
    output logic [7:0]        p0_dout,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_din,
    output logic              p1_ack,
    output logic [7:0]        p1_dout,

    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [7:0]        p2_din,
    output logic              p2_ack,
    output logic [7:0]        p2_dout,

    output logic              clkref,
    output logic              oe,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        din,
    input  logic [7:0]        dout,
    output logic              busy
);

    logic pre_end;
    logic slot_end;
    logic force_idle;
    logic grant_vld;

    port_req_t            reqs [NUM_PORTS];
    port_req_t            sel_req;
    grant_t               sel;
    grant_t               grant_q;
    logic [NUM_PORTS-1:0] ack_q;
    logic [7:0]           dout_q [NUM_PORTS];

    sdram_slot_timer #(
        .SLOT_CLKS     (SLOT_CLKS),
        .REFRESH_EVERY (REFRESH_EVERY)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .grant_vld  (grant_vld),
        .clkref     (clkref),
        .pre_end    (pre_end),
        .slot_end   (slot_end),
        .force_idle (force_idle)
    );

    always_comb begin
        reqs[0] = '{req: p0_req, we: p0_we, addr: SDRAM_ADDR_W'(p0_addr), din: p0_din};
        reqs[1] = '{req: p1_req, we: p1_we, addr: SDRAM_ADDR_W'(p1_addr), din: p1_din};
        reqs[2] = '{req: p2_req, we: p2_we, addr: SDRAM_ADDR_W'(p2_addr), din: p2_din};
    end

    // Lowest index wins; a port being acked this cycle still shows its old
    // req, so it is masked out to avoid re-granting the finished request.
    always_comb begin
        sel     = PORT_NONE;
        sel_req = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (reqs[i].req && !ack_q[i]) begin
                sel     = grant_t'(i);
                sel_req = reqs[i];
            end
        end
        grant_vld = (sel != PORT_NONE) && !force_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= PORT_NONE;
            ack_q   <= '0;
            oe      <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            din     <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            ack_q <= '0;

            // registering here makes the ack visible during the last phase
            if (pre_end) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == grant_t'(i)) begin
                        ack_q[i] <= 1'b1;
                        if (!we) begin
                            dout_q[i] <= dout;
                        end
                    end
                end
            end

            if (slot_end) begin
                if (grant_vld) begin
                    grant_q <= sel;
                    oe      <= !sel_req.we;
                    we      <= sel_req.we;
                    addr    <= ADDR_W'(sel_req.addr);
                    din     <= sel_req.din;
                    busy    <= 1'b1;
                end else begin
                    grant_q <= PORT_NONE;
                    oe      <= 1'b0;
                    we      <= 1'b0;
                    addr    <= '0;
                    din     <= '0;
                    busy    <= 1'b0;
                end
            end
        end
    end

    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];
    assign p0_dout = dout_q[0];
    assign p1_dout = dout_q[1];
    assign p2_dout = dout_q[2];

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: single transactions from a vector table,
// then priority ordering, refresh spacing and mid-slot reset sequences.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
    logic [24:0] p0_addr, p1_addr, p2_addr;
    logic [7:0]  p0_din, p1_din, p2_din;
    logic        p0_ack, p1_ack, p2_ack;
    logic [7:0]  p0_dout, p1_dout, p2_dout;
    logic        clkref, oe, we, busy;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout_m;
    logic [2:0]  acks;

    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] tcyc;

    always #5 clk = ~clk;

    sdram_port_arb dut (
        .clk     (clk),     .reset   (reset),
        .p0_req  (p0_req),  .p0_we   (p0_we),  .p0_addr (p0_addr), .p0_din (p0_din),
        .p0_ack  (p0_ack),  .p0_dout (p0_dout),
        .p1_req  (p1_req),  .p1_we   (p1_we),  .p1_addr (p1_addr), .p1_din (p1_din),
        .p1_ack  (p1_ack),  .p1_dout (p1_dout),
        .p2_req  (p2_req),  .p2_we   (p2_we),  .p2_addr (p2_addr), .p2_din (p2_din),
        .p2_ack  (p2_ack),  .p2_dout (p2_dout),
        .clkref  (clkref),  .oe      (oe),     .we      (we),
        .addr    (addr),    .din     (din),    .dout    (dout_m),  .busy   (busy)
    );

    // memory stand-in: read data derived from the low address byte
    always_comb dout_m = oe ? (addr[7:0] ^ 8'hC3) : 8'h00;
    assign acks = {p2_ack, p1_ack, p0_ack};

    // reference phase: cycles since the last reset edge
    always @(posedge clk) begin
        if (reset) tcyc <= 0;
        else       tcyc <= tcyc + 1;
    end

    function automatic int ph_m();
        return int'(tcyc % 16);
    endfunction

    function automatic logic [7:0] get_dout(input int p);
        case (p)
            0:       return p0_dout;
            1:       return p1_dout;
            default: return p2_dout;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [24:0] a, input logic [7:0] d);
        case (p)
            0:       begin p0_req = r; p0_we = w; p0_addr = a; p0_din = d; end
            1:       begin p1_req = r; p1_we = w; p1_addr = a; p1_din = d; end
            default: begin p2_req = r; p2_we = w; p2_addr = a; p2_din = d; end
        endcase
    endtask

    task automatic wait_ph(input int p);
        do @(negedge clk); while (ph_m() != p);
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [24:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_dout;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    initial begin
        int bad, nack, k0, k1, k2, ackt;
        logic [2:0] exp_ack;

        vt[0] = '{1, 1'b1, 25'h0001234, 8'h5A, 8'h00};
        vt[1] = '{2, 1'b0, 25'h0000100, 8'h00, 8'hC3};
        vt[2] = '{0, 1'b0, 25'h1ABCDEF, 8'h00, 8'h2C};
        vt[3] = '{0, 1'b1, 25'h1FFFFFF, 8'hFF, 8'h2C};
        vt[4] = '{1, 1'b0, 25'h0000042, 8'h00, 8'h81};
        vt[5] = '{2, 1'b1, 25'h0000000, 8'hA5, 8'hC3};

        reset = 1'b1;
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state visible in the cycle after the last reset edge
        chk("rst_oe_we_busy", {oe, we, busy}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_acks", acks, 0);
        chk("rst_douts", {p0_dout, p1_dout, p2_dout}, 0);

        // idle running: clkref 8 high / 8 low from ph 0, nothing requested
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            chk("clkref", clkref, (tcyc != 0 && ph_m() < 8));
            if (oe || we || busy || acks != 0) bad++;
            @(negedge clk);
        end
        chk("idle_quiet", bad, 0);

        // single transactions
        for (int v = 0; v < NV; v++) begin
            wait_ph(15);
            set_port(vt[v].port, 1'b1, vt[v].wr, vt[v].a, vt[v].d);
            bad = 0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if (oe !== !vt[v].wr || we !== vt[v].wr || addr !== vt[v].a ||
                    din !== vt[v].d || busy !== 1'b1) bad++;
                if (k < 16 && acks !== 3'b000) bad++;
            end
            chk("vec_slot_signals", bad, 0);
            exp_ack = 3'b001 << vt[v].port;
            chk("vec_ack_ph15", acks, exp_ack);
            set_port(vt[v].port, 1'b0, vt[v].wr, vt[v].a, vt[v].d);
            @(negedge clk);
            chk("vec_ack_clear", acks, 0);
            chk("vec_dout", get_dout(vt[v].port), vt[v].exp_dout);
            chk("vec_idle_after", {oe, we, busy}, 0);
        end

        // simultaneous requests: served p0, p1, p2 in consecutive slots
        wait_ph(15);
        set_port(0, 1'b1, 1'b0, 25'h0000300, 8'h00);
        set_port(1, 1'b1, 1'b1, 25'h0000301, 8'h11);
        set_port(2, 1'b1, 1'b0, 25'h0000302, 8'h00);
        k0 = 0; k1 = 0; k2 = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (k == 1)  chk("prio_addr0", {oe, we, addr}, {2'b10, 25'h0000300});
            if (k == 17) chk("prio_addr1", {oe, we, addr}, {2'b01, 25'h0000301});
            if (k == 33) chk("prio_addr2", {oe, we, addr}, {2'b10, 25'h0000302});
            if (p0_ack && k0 == 0) begin k0 = k; p0_req = 1'b0; end
            if (p1_ack && k1 == 0) begin k1 = k; p1_req = 1'b0; end
            if (p2_ack && k2 == 0) begin k2 = k; p2_req = 1'b0; end
        end
        chk("prio_ack0_cycle", k0, 16);
        chk("prio_ack1_cycle", k1, 32);
        chk("prio_ack2_cycle", k2, 48);
        chk("prio_p0_dout", p0_dout, 8'hC3);
        chk("prio_p2_dout", p2_dout, 8'hC1);

        // p0 and p1 held: they alternate, and every 8th slot is a refresh gap
        wait_ph(15);
        set_port(0, 1'b1, 1'b0, 25'h0000010, 8'h00);
        set_port(1, 1'b1, 1'b0, 25'h0000020, 8'h00);
        nack = 0;
        for (int s = 0; s < 20; s++) begin
            for (int p = 0; p < 16; p++) begin
                @(negedge clk);
                if (p == 8) chk("refresh_oe", oe, (s % 8) != 7);
                if (p == 15) begin
                    if (s % 8 == 7)          exp_ack = 3'b000;
                    else if (s % 2 == 0)     exp_ack = 3'b001;
                    else                     exp_ack = 3'b010;
                    chk("refresh_ack", acks, exp_ack);
                    nack += int'(p0_ack) + int'(p1_ack) + int'(p2_ack);
                end
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("refresh_total_acks", nack, 18);
        chk("refresh_p0_dout", p0_dout, 8'hD3);
        chk("refresh_p1_dout", p1_dout, 8'hE3);

        // reset at ph 6 of a p1 read slot
        wait_ph(15);
        set_port(1, 1'b1, 1'b0, 25'h0000055, 8'h00);
        bad = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) chk("midrst_slot_oe", oe, 1'b1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_outputs", {clkref, oe, we, busy}, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_acks", acks, 0);
        chk("midrst_p1_dout", p1_dout, 0);
        nack = 0;
        ackt = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tcyc == 16) chk("midrst_regrant", {oe, addr}, {1'b1, 25'h0000055});
            if (p1_ack) begin
                nack++;
                ackt = int'(tcyc);
                p1_req = 1'b0;
            end
            if (p0_ack || p2_ack) bad++;
        end
        chk("midrst_ack_count", nack, 1);
        chk("midrst_ack_cycle", ackt, 31);
        chk("midrst_other_acks", bad, 0);
        chk("midrst_p1_dout_after", p1_dout, 8'h96);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
